// File: rtl/mux_scan_sequencer.sv
// Sequencer in front of a combinational 2**SEL_W:1 mux: steps the select, waits SETTLE
// cycles per input, samples mux_y once per input and hands the assembled word out on valid/ready.
module mux_scan_sequencer #(
  parameter int SEL_W  = 3,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  output logic [SEL_W-1:0]      sel,
  input  logic                  mux_y,
  output logic [2**SEL_W-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int         N        = 2**SEL_W;
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [3:0]       r_cnt;
  logic [N-1:0]     r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_start_ready;

  // With SETTLE==0 there is nothing to wait for, so each select goes straight to sampling.
  localparam state_t SETTLE_STATE = (SETTLE_C == 4'd0) ? S_SAMPLE : S_WAIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_sel         <= '0;
      r_cnt         <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_start_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_sel         <= '0;
            r_data        <= '0;
            r_cnt         <= SETTLE_C;
            r_busy        <= 1'b1;
            r_start_ready <= 1'b0;
            r_state       <= SETTLE_STATE;
          end
        end

        // Counter holds the remaining settle cycles; leaving on 1 gives exactly SETTLE cycles here.
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          r_data[r_sel] <= mux_y;
          if (r_sel == LAST_SEL) begin
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_sel   <= r_sel + SEL_W'(1);
            r_cnt   <= SETTLE_C;
            r_state <= SETTLE_STATE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_valid       <= 1'b0;
            r_sel         <= '0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_valid       <= 1'b0;
          r_sel         <= '0;
          r_busy        <= 1'b0;
          r_start_ready <= 1'b1;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign sel         = r_sel;
  assign out_data    = r_data;
  assign out_valid   = r_valid;
  assign busy        = r_busy;
  assign start_ready = r_start_ready;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: default instance (SETTLE=1) and a SETTLE=0 instance,
// each driven by a behavioural 8:1 mux model.
module tb_mux_scan_sequencer;

  logic       clk;
  logic       rst_n;

  logic       startValid;
  logic       startReady;
  logic [2:0] sel;
  logic       muxY;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic       busy;
  logic [7:0] muxD;
  logic       maskNow;

  logic       s0StartValid;
  logic       s0StartReady;
  logic [2:0] s0Sel;
  logic       s0MuxY;
  logic [7:0] s0OutData;
  logic       s0OutValid;
  logic       s0OutReady;
  logic       s0Busy;
  logic [7:0] s0MuxD;

  int testCount = 0;
  int failCount = 0;

  assign muxY   = maskNow ? 1'b0 : muxD[sel];
  assign s0MuxY = s0MuxD[s0Sel];

  mux_scan_sequencer #(.SEL_W(3), .SETTLE(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (startValid),
    .start_ready (startReady),
    .sel         (sel),
    .mux_y       (muxY),
    .out_data    (outData),
    .out_valid   (outValid),
    .out_ready   (outReady),
    .busy        (busy)
  );

  mux_scan_sequencer #(.SEL_W(3), .SETTLE(0)) dutS0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (s0StartValid),
    .start_ready (s0StartReady),
    .sel         (s0Sel),
    .mux_y       (s0MuxY),
    .out_data    (s0OutData),
    .out_valid   (s0OutValid),
    .out_ready   (s0OutReady),
    .busy        (s0Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Starts one scan on the SETTLE=1 instance from a negedge in IDLE and follows it to DONE.
  // Bit k spends the cycle after edge 2k in WAIT and the cycle after edge 2k+1 in SAMPLE.
  task automatic applyStimulus(input logic [7:0] d, input logic maskEn, input int maskBit,
                               input logic holdStart, input logic [7:0] expWord);
    muxD       = d;
    maskNow    = 1'b0;
    startValid = 1'b1;
    @(negedge clk);
    if (!holdStart) startValid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      checkOutput("scan_sel", 32'(sel), 32'(c / 2));
      checkOutput("scan_busy", 32'(busy), 32'd1);
      checkOutput("scan_start_ready", 32'(startReady), 32'd0);
      checkOutput("scan_valid_early", 32'(outValid), 32'd0);
      maskNow = maskEn && ((c / 2) == maskBit) && ((c % 2) == 0);
      @(negedge clk);
    end
    maskNow = 1'b0;
    checkOutput("done_valid", 32'(outValid), 32'd1);
    checkOutput("done_data", 32'(outData), 32'(expWord));
    checkOutput("done_sel", 32'(sel), 32'd7);
    checkOutput("done_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    startValid   = 1'b0;
    outReady     = 1'b1;
    muxD         = 8'h00;
    maskNow      = 1'b0;
    s0StartValid = 1'b0;
    s0OutReady   = 1'b1;
    s0MuxD       = 8'h00;

    // Reset values, held while rst_n is low and kept after release with no start.
    repeat (2) @(negedge clk);
    checkOutput("rst_start_ready", 32'(startReady), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_sel", 32'(sel), 32'd0);
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_data", 32'(outData), 32'd0);
    checkOutput("rst_s0_ready", 32'(s0StartReady), 32'd1);
    checkOutput("rst_s0_busy", 32'(s0Busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_valid", 32'(outValid), 32'd0);

    $display("[TB] basic scan D=B2");
    applyStimulus(8'hB2, 1'b0, 0, 1'b0, 8'hB2);
    @(negedge clk);
    checkOutput("basic_valid_drop", 32'(outValid), 32'd0);
    checkOutput("basic_start_ready", 32'(startReady), 32'd1);
    checkOutput("basic_sel_back", 32'(sel), 32'd0);
    checkOutput("basic_data_kept", 32'(outData), 32'hB2);
    checkOutput("basic_busy", 32'(busy), 32'd0);

    $display("[TB] backpressure");
    outReady = 1'b0;
    applyStimulus(8'hB2, 1'b0, 0, 1'b0, 8'hB2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid_hold", 32'(outValid), 32'd1);
      checkOutput("bp_data_hold", 32'(outData), 32'hB2);
      checkOutput("bp_sel_hold", 32'(sel), 32'd7);
    end
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("bp_valid_drop", 32'(outValid), 32'd0);
    checkOutput("bp_start_ready", 32'(startReady), 32'd1);
    checkOutput("bp_sel_back", 32'(sel), 32'd0);

    $display("[TB] settle isolation on bit 3");
    applyStimulus(8'hBA, 1'b1, 3, 1'b0, 8'hBA);
    @(negedge clk);
    checkOutput("settle_valid_drop", 32'(outValid), 32'd0);

    $display("[TB] back-to-back with start held");
    applyStimulus(8'h5A, 1'b0, 0, 1'b1, 8'h5A);
    @(negedge clk);
    checkOutput("b2b_idle_ready", 32'(startReady), 32'd1);
    checkOutput("b2b_idle_busy", 32'(busy), 32'd0);
    checkOutput("b2b_idle_valid", 32'(outValid), 32'd0);
    checkOutput("b2b_data_kept", 32'(outData), 32'h5A);
    applyStimulus(8'hC3, 1'b0, 0, 1'b1, 8'hC3);
    startValid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_end_valid", 32'(outValid), 32'd0);
    @(negedge clk);
    checkOutput("b2b_no_restart", 32'(busy), 32'd0);

    $display("[TB] reset mid-scan");
    muxD       = 8'hFF;
    startValid = 1'b1;
    @(negedge clk);
    startValid = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("mid_sel_before", 32'(sel), 32'd4);
    checkOutput("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_sel", 32'(sel), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_valid", 32'(outValid), 32'd0);
    checkOutput("mid_data", 32'(outData), 32'd0);
    checkOutput("mid_start_ready", 32'(startReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("post_rst_valid", 32'(outValid), 32'd0);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
    end

    $display("[TB] SETTLE=0 instance");
    s0MuxD       = 8'hFF;
    s0StartValid = 1'b1;
    @(negedge clk);
    s0StartValid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checkOutput("s0_sel", 32'(s0Sel), 32'(c));
      checkOutput("s0_valid_early", 32'(s0OutValid), 32'd0);
      checkOutput("s0_busy", 32'(s0Busy), 32'd1);
      @(negedge clk);
    end
    checkOutput("s0_valid", 32'(s0OutValid), 32'd1);
    checkOutput("s0_data_ff", 32'(s0OutData), 32'hFF);
    @(negedge clk);
    checkOutput("s0_valid_drop", 32'(s0OutValid), 32'd0);
    checkOutput("s0_start_ready", 32'(s0StartReady), 32'd1);

    s0MuxD       = 8'h96;
    s0StartValid = 1'b1;
    @(negedge clk);
    s0StartValid = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("s0_valid_2", 32'(s0OutValid), 32'd1);
    checkOutput("s0_data_96", 32'(s0OutData), 32'h96);
    @(negedge clk);
    checkOutput("s0_valid_drop_2", 32'(s0OutValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Control stage directly upstream of the 8:1 select mux. On a start handshake it steps the mux select through every input, holds each select for a settle interval, and samples the mux output once per input. It assembles the sampled bits into a parallel word and presents the word on a valid/ready output. The mux stays purely combinational; this block owns all sequencing and timing around it.

Parameters:
SEL_W, 3, select width; number of mux inputs N = 2**SEL_W (default 8).
SETTLE, 1, wait cycles after each select change before sampling; legal range 0..15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start_valid  input  1  request to begin a scan.
start_ready  output  1  high only in IDLE.
sel  output  SEL_W  select driven to the mux.
mux_y  input  1  mux output; sampled combinationally from the current sel.
out_data  output  N  assembled word; bit i is the mux output sampled with sel==i.
out_valid  output  1  out_data is complete and stable.
out_ready  input  1  consumer accepts out_data.
busy  output  1  high in WAIT, SAMPLE or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, sel=0, wait counter=0, out_data=0, out_valid=0, busy=0, start_ready=1. All outputs stay at these values until rst_n rises.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid at a clock edge: sel<=0, out_data<=0, counter<=SETTLE.
  - Next state is WAIT, or SAMPLE if SETTLE==0.
- WAIT:
  - Counter decrements each cycle.
  - Go to SAMPLE on the edge where the counter reaches 0.
  - The block spends exactly SETTLE cycles in WAIT per bit.
  - mux_y is ignored in WAIT.
- SAMPLE: one cycle. At the closing edge, out_data[sel]<=mux_y. Then:
  - If sel==N-1: go to DONE.
  - Otherwise: sel<=sel+1, counter<=SETTLE, next state is WAIT (or SAMPLE again if SETTLE==0).
- DONE:
  - out_valid=1.
  - out_data and sel (=N-1) are held stable while out_ready is low.
  - On out_ready high at an edge: out_valid<=0, sel<=0, return to IDLE.
  - out_data keeps its value after the handshake until the next accept.
- Latency: out_valid rises exactly N*(SETTLE+1) clock edges after the accepting edge (16 for the defaults, 8 for SETTLE=0).
- Throughput: one start per completed handshake. No overlap of scans.
- start_valid outside IDLE is ignored. It is not queued and start_ready=0.
- A start_valid held high through a DONE handshake is accepted on the first IDLE cycle. The minimum gap from the output handshake to the next accept is 1 cycle.
- sel wrap-around: sel never increments past N-1. The increment is suppressed in the last SAMPLE.
- rst_n asserted mid-scan: immediate return to reset values. A partial word is discarded and out_valid is never raised for it.
- busy = (state != IDLE).

Test Plan:
- Basic scan: bench mux model has D=8'b1011_0010 (mux_y = D[sel]). Pulse start_valid one cycle -> sel walks 0..7, each value held 2 cycles; out_valid rises on edge 16 after accept; out_data=8'hB2.
- Backpressure: same scan, out_ready low for 5 cycles after out_valid -> out_data=8'hB2 and sel=7 stable all 5 cycles; out_valid falls one edge after out_ready rises; start_ready=1 next cycle.
- Settle isolation: D bit 3 =1, but the bench forces mux_y=0 during the WAIT cycles of sel==3 -> out_data[3]=1; only the SAMPLE-cycle value is captured.
- Ignored start / back-to-back: start_valid held high continuously with D=8'h5A, then D=8'hC3, out_ready=1 -> first word 8'h5A; start pulses during the scan have no effect; second accept on the first IDLE cycle; second word 8'hC3.
- Reset mid-scan: assert rst_n low while sel==4 -> same cycle: sel=0, busy=0, out_valid=0, out_data=0; after release no out_valid until a new start.
- SETTLE=0 variant: D=8'hFF -> sel changes every cycle 0..7; out_valid on edge 8 after accept; out_data=8'hFF.
